blit_sdram_port: RTL and testbench

- Downstream of the blitter. Merges the blitter's burst-read client (blitr_*) and single-word write client (blitw_*) into one SDRAM arbiter master port.
- Write-biased arbitration keeps the blitter write FIFO draining.
- A bounded write run guarantees reads make progress.
- A same-line hazard check stops a read from returning data that a pending write is about to overwrite.

---
 rtl/blit_sdram_port.sv | 150 +++++++++++++++
 tb/tb_blit_sdram_port.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_sdram_port.sv
// Merges the blitter burst-read client and single-word write client onto one SDRAM arbiter master port.
// Writes are favoured, bounded by a run limit while a read waits, with a same-line hazard override.
module blit_sdram_port #(
    parameter int BURST_WORDS   = 4,
    parameter int LINE_BITS     = 4,
    parameter int MAX_WRITE_RUN = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        blitr_sdram_request,
    input  logic [25:0] blitr_sdram_address,
    output logic        blitr_sdram_ready,
    output logic        blitr_sdram_rvalid,
    output logic [31:0] blitr_sdram_rdata,
    output logic [25:0] blitr_sdram_raddress,
    output logic        blitr_sdram_complete,
    input  logic        blitw_sdram_request,
    input  logic [25:0] blitw_sdram_address,
    input  logic [3:0]  blitw_sdram_wstrb,
    input  logic [31:0] blitw_sdram_wdata,
    output logic        blitw_sdram_ready,
    output logic        sdram_request,
    output logic        sdram_write,
    output logic [25:0] sdram_address,
    output logic [3:0]  sdram_wstrb,
    output logic [31:0] sdram_wdata,
    input  logic        sdram_ready,
    input  logic        sdram_rvalid,
    input  logic [31:0] sdram_rdata,
    input  logic [25:0] sdram_raddress,
    input  logic        sdram_complete
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_READ_REQ  = 2'd2;
    localparam logic [1:0] ST_READ_DATA = 2'd3;

    localparam int BURST_LINE_BITS = $clog2(BURST_WORDS) + 2;
    // Should the two line-size parameters ever disagree, compare on the larger line so the hazard stays conservative.
    localparam int LINE_LSB = (LINE_BITS > BURST_LINE_BITS) ? LINE_BITS : BURST_LINE_BITS;
    localparam logic [7:0] RUN_LIMIT = 8'(MAX_WRITE_RUN);

    logic [1:0]  state_q, state_d;
    logic [7:0]  run_cnt_q, run_cnt_d;
    logic        sdram_request_q, sdram_request_d;
    logic        sdram_write_q, sdram_write_d;
    logic [25:0] sdram_address_q, sdram_address_d;
    logic [3:0]  sdram_wstrb_q, sdram_wstrb_d;
    logic [31:0] sdram_wdata_q, sdram_wdata_d;

    logic hazard;
    logic write_wins;
    logic in_burst;

    assign hazard = blitw_sdram_request && blitr_sdram_request &&
                    (blitw_sdram_address[25:LINE_LSB] == blitr_sdram_address[25:LINE_LSB]);
    assign write_wins = blitw_sdram_request &&
                        (!blitr_sdram_request || hazard || (run_cnt_q < RUN_LIMIT));

    always_comb begin
        state_d         = state_q;
        run_cnt_d       = run_cnt_q;
        sdram_request_d = sdram_request_q;
        sdram_write_d   = sdram_write_q;
        sdram_address_d = sdram_address_q;
        sdram_wstrb_d   = sdram_wstrb_q;
        sdram_wdata_d   = sdram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (write_wins) begin
                    state_d         = ST_WRITE;
                    sdram_request_d = 1'b1;
                    sdram_write_d   = 1'b1;
                    sdram_address_d = blitw_sdram_address;
                    sdram_wstrb_d   = blitw_sdram_wstrb;
                    sdram_wdata_d   = blitw_sdram_wdata;
                end else if (blitr_sdram_request) begin
                    state_d         = ST_READ_REQ;
                    sdram_request_d = 1'b1;
                    sdram_write_d   = 1'b0;
                    sdram_address_d = blitr_sdram_address;
                    sdram_wstrb_d   = 4'h0;
                end
            end
            ST_WRITE: begin
                if (sdram_ready) begin
                    state_d         = ST_IDLE;
                    sdram_request_d = 1'b0;
                    // Only writes that overtook a waiting read count towards the run limit.
                    if (blitr_sdram_request && (run_cnt_q != 8'hFF)) begin
                        run_cnt_d = run_cnt_q + 8'd1;
                    end
                end
            end
            ST_READ_REQ: begin
                if (sdram_ready) begin
                    state_d         = ST_READ_DATA;
                    sdram_request_d = 1'b0;
                    run_cnt_d       = 8'd0;
                end
            end
            ST_READ_DATA: begin
                if (sdram_rvalid && sdram_complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            run_cnt_q       <= 8'd0;
            sdram_request_q <= 1'b0;
            sdram_write_q   <= 1'b0;
            sdram_address_q <= 26'd0;
            sdram_wstrb_q   <= 4'h0;
            sdram_wdata_q   <= 32'd0;
        end else begin
            state_q         <= state_d;
            run_cnt_q       <= run_cnt_d;
            sdram_request_q <= sdram_request_d;
            sdram_write_q   <= sdram_write_d;
            sdram_address_q <= sdram_address_d;
            sdram_wstrb_q   <= sdram_wstrb_d;
            sdram_wdata_q   <= sdram_wdata_d;
        end
    end

    assign sdram_request = sdram_request_q;
    assign sdram_write   = sdram_write_q;
    assign sdram_address = sdram_address_q;
    assign sdram_wstrb   = sdram_wstrb_q;
    assign sdram_wdata   = sdram_wdata_q;

    assign blitw_sdram_ready = (state_q == ST_WRITE) && sdram_ready;
    assign blitr_sdram_ready = (state_q == ST_READ_REQ) && sdram_ready;

    // Read data is only forwarded for the burst this port owns; strays outside it are dropped.
    assign in_burst             = (state_q == ST_READ_DATA);
    assign blitr_sdram_rvalid   = in_burst && sdram_rvalid;
    assign blitr_sdram_rdata    = blitr_sdram_rvalid ? sdram_rdata : 32'd0;
    assign blitr_sdram_raddress = blitr_sdram_rvalid ? sdram_raddress : 26'd0;
    assign blitr_sdram_complete = in_burst && sdram_complete;

endmodule

// File: tb/tb_blit_sdram_port.sv
// Randomised and directed bench for blit_sdram_port: transaction-level reference model checked every cycle.
module tb_blit_sdram_port;

    localparam int BW  = 4;
    localparam int LB  = 4;
    localparam int MWR = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        blitr_sdram_request = 1'b0;
    logic [25:0] blitr_sdram_address = 26'd0;
    logic        blitr_sdram_ready;
    logic        blitr_sdram_rvalid;
    logic [31:0] blitr_sdram_rdata;
    logic [25:0] blitr_sdram_raddress;
    logic        blitr_sdram_complete;
    logic        blitw_sdram_request = 1'b0;
    logic [25:0] blitw_sdram_address = 26'd0;
    logic [3:0]  blitw_sdram_wstrb = 4'h0;
    logic [31:0] blitw_sdram_wdata = 32'd0;
    logic        blitw_sdram_ready;
    logic        sdram_request;
    logic        sdram_write;
    logic [25:0] sdram_address;
    logic [3:0]  sdram_wstrb;
    logic [31:0] sdram_wdata;
    logic        sdram_ready = 1'b0;
    logic        sdram_rvalid = 1'b0;
    logic [31:0] sdram_rdata = 32'd0;
    logic [25:0] sdram_raddress = 26'd0;
    logic        sdram_complete = 1'b0;

    blit_sdram_port #(.BURST_WORDS(BW), .LINE_BITS(LB), .MAX_WRITE_RUN(MWR)) dut (
        .clock(clock), .reset(reset),
        .blitr_sdram_request(blitr_sdram_request), .blitr_sdram_address(blitr_sdram_address),
        .blitr_sdram_ready(blitr_sdram_ready), .blitr_sdram_rvalid(blitr_sdram_rvalid),
        .blitr_sdram_rdata(blitr_sdram_rdata), .blitr_sdram_raddress(blitr_sdram_raddress),
        .blitr_sdram_complete(blitr_sdram_complete),
        .blitw_sdram_request(blitw_sdram_request), .blitw_sdram_address(blitw_sdram_address),
        .blitw_sdram_wstrb(blitw_sdram_wstrb), .blitw_sdram_wdata(blitw_sdram_wdata),
        .blitw_sdram_ready(blitw_sdram_ready),
        .sdram_request(sdram_request), .sdram_write(sdram_write), .sdram_address(sdram_address),
        .sdram_wstrb(sdram_wstrb), .sdram_wdata(sdram_wdata), .sdram_ready(sdram_ready),
        .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata), .sdram_raddress(sdram_raddress),
        .sdram_complete(sdram_complete)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [25:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        wr;
        logic [25:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } grant_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the request currently offered to the arbiter, and whether a burst is owed to us.
    logic        m_req = 1'b0;
    logic        m_wr = 1'b0;
    logic [25:0] m_addr = 26'd0;
    logic [3:0]  m_strb = 4'h0;
    logic [31:0] m_data = 32'd0;
    logic        m_burst = 1'b0;
    int          m_run = 0;

    // Client agents
    wr_t         wq[$];
    logic [25:0] rq[$];
    wr_t         w_cur = '0;
    logic [25:0] r_cur = 26'd0;
    logic        w_pend = 1'b0;
    logic        r_pend = 1'b0;
    logic        auto_w = 1'b0;
    logic        auto_r = 1'b0;
    int          w_pct = 0;
    int          r_pct = 0;
    logic [25:0] w_base = 26'd0;
    logic [25:0] r_base = 26'd0;

    // Arbiter agent
    int          ready_wait = 0;
    int          req_age = 0;
    logic        rand_wait = 1'b0;
    int          rv_pct = 100;
    int          rv_limit = BW;
    int          burst_left = 0;
    logic [25:0] burst_base = 26'd0;
    logic        stray_en = 1'b0;

    // Observations from the last sample point
    logic        obs_w_acc = 1'b0;
    logic        obs_r_acc = 1'b0;
    logic        obs_arb_rd = 1'b0;
    logic [25:0] obs_addr = 26'd0;
    logic        lit_zero = 1'b0;

    grant_t      grants[$];
    logic [25:0] rv_addr[$];
    logic [31:0] rv_data[$];
    logic [31:0] sent_data[$];
    int          bw_ready_cnt = 0;
    int          bw_bad = 0;
    int          req_cycles = 0;
    int          cpl_cnt = 0;
    int          cpl_idx = 0;
    int          rd_grants = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic w, r, haz;
        w = blitw_sdram_request;
        r = blitr_sdram_request;
        if (reset) begin
            m_req = 1'b0; m_wr = 1'b0; m_addr = 26'd0; m_strb = 4'h0; m_data = 32'd0;
            m_burst = 1'b0; m_run = 0;
        end else if (m_req) begin
            if (sdram_ready) begin
                m_req = 1'b0;
                if (m_wr) begin
                    if (r) m_run = (m_run >= 255) ? 255 : m_run + 1;
                end else begin
                    m_run = 0;
                    m_burst = 1'b1;
                end
            end
        end else if (m_burst) begin
            if (sdram_rvalid && sdram_complete) m_burst = 1'b0;
        end else begin
            haz = w && r && ((blitw_sdram_address >> LB) == (blitr_sdram_address >> LB));
            if (w && (!r || haz || m_run < MWR)) begin
                m_req = 1'b1; m_wr = 1'b1; m_addr = blitw_sdram_address;
                m_strb = blitw_sdram_wstrb; m_data = blitw_sdram_wdata;
            end else if (r) begin
                m_req = 1'b1; m_wr = 1'b0; m_addr = blitr_sdram_address; m_strb = 4'h0;
            end
        end
    endtask

    task automatic sample();
        logic e_rv;
        @(negedge clock);
        e_rv = m_burst && sdram_rvalid;
        chk("sdram_request", 64'(sdram_request), 64'(m_req));
        chk("sdram_write", 64'(sdram_write), 64'(m_wr));
        chk("sdram_address", 64'(sdram_address), 64'(m_addr));
        chk("sdram_wstrb", 64'(sdram_wstrb), 64'(m_strb));
        chk("sdram_wdata", 64'(sdram_wdata), 64'(m_data));
        chk("blitw_ready", 64'(blitw_sdram_ready), 64'(m_req && m_wr && sdram_ready));
        chk("blitr_ready", 64'(blitr_sdram_ready), 64'(m_req && !m_wr && sdram_ready));
        chk("blitr_rvalid", 64'(blitr_sdram_rvalid), 64'(e_rv));
        chk("blitr_rdata", 64'(blitr_sdram_rdata), e_rv ? 64'(sdram_rdata) : 64'd0);
        chk("blitr_raddress", 64'(blitr_sdram_raddress), e_rv ? 64'(sdram_raddress) : 64'd0);
        chk("blitr_complete", 64'(blitr_sdram_complete), 64'(m_burst && sdram_complete));
        if (lit_zero) begin
            lit_zero = 1'b0;
            chk("zero_request", 64'(sdram_request), 64'd0);
            chk("zero_write", 64'(sdram_write), 64'd0);
            chk("zero_address", 64'(sdram_address), 64'd0);
            chk("zero_wstrb_wdata", {28'd0, sdram_wstrb, sdram_wdata}, 64'd0);
            chk("zero_readies", 64'({blitr_sdram_ready, blitw_sdram_ready}), 64'd0);
            chk("zero_rvalid_complete", 64'({blitr_sdram_rvalid, blitr_sdram_complete}), 64'd0);
        end
        obs_w_acc  = blitw_sdram_ready;
        obs_r_acc  = blitr_sdram_ready;
        obs_arb_rd = sdram_request && !sdram_write && sdram_ready;
        obs_addr   = sdram_address;
        if (blitw_sdram_ready) grants.push_back({1'b1, sdram_address, sdram_wstrb, sdram_wdata});
        if (blitr_sdram_ready) begin
            grants.push_back({1'b0, sdram_address, 4'h0, 32'd0});
            rd_grants++;
        end
        if (blitw_sdram_ready) bw_ready_cnt++;
        if (blitw_sdram_ready && !sdram_ready) bw_bad++;
        if (sdram_request) req_cycles++;
        if (blitr_sdram_rvalid) begin
            rv_addr.push_back(blitr_sdram_raddress);
            rv_data.push_back(blitr_sdram_rdata);
            if (blitr_sdram_complete) cpl_idx = rv_addr.size();
        end
        if (blitr_sdram_complete) cpl_cnt++;
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        model_step();
        if (obs_w_acc) w_pend = 1'b0;
        if (!w_pend) begin
            if (wq.size() > 0) begin
                w_cur = wq.pop_front();
                w_pend = 1'b1;
            end else if (auto_w && $urandom_range(0, 99) < w_pct) begin
                w_cur.addr = w_base + 26'($urandom_range(0, 31) * 4);
                w_cur.strb = 4'($urandom_range(1, 15));
                w_cur.data = $urandom;
                w_pend = 1'b1;
            end
        end
        blitw_sdram_request = w_pend;
        blitw_sdram_address = w_cur.addr;
        blitw_sdram_wstrb   = w_cur.strb;
        blitw_sdram_wdata   = w_cur.data;
        if (obs_r_acc) r_pend = 1'b0;
        if (!r_pend) begin
            if (rq.size() > 0) begin
                r_cur = rq.pop_front();
                r_pend = 1'b1;
            end else if (auto_r && $urandom_range(0, 99) < r_pct) begin
                r_cur = r_base + 26'($urandom_range(0, 7) * 16);
                r_pend = 1'b1;
            end
        end
        blitr_sdram_request = r_pend;
        blitr_sdram_address = r_cur;
        if (obs_arb_rd) begin
            burst_left = BW;
            burst_base = obs_addr;
        end
        if (sdram_request && !reset) begin
            if (req_age == 0 && rand_wait) ready_wait = $urandom_range(0, 3);
            sdram_ready = (req_age >= ready_wait);
            req_age++;
        end else begin
            sdram_ready = 1'b0;
            req_age = 0;
        end
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;
        sdram_rdata    = $urandom;
        sdram_raddress = 26'($urandom);
        if (!reset && burst_left > 0 && (BW - burst_left) < rv_limit &&
            $urandom_range(0, 99) < rv_pct) begin
            sdram_rvalid   = 1'b1;
            sdram_raddress = burst_base + 26'(4 * (BW - burst_left));
            sdram_complete = (burst_left == 1);
            sent_data.push_back(sdram_rdata);
            burst_left--;
        end else if (stray_en && burst_left == 0 && $urandom_range(0, 99) < 5) begin
            sdram_rvalid   = 1'b1;
            sdram_complete = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic clear_logs();
        grants.delete(); rv_addr.delete(); rv_data.delete(); sent_data.delete();
        bw_ready_cnt = 0; bw_bad = 0; req_cycles = 0; cpl_cnt = 0; cpl_idx = 0; rd_grants = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wq.delete(); rq.delete();
        w_pend = 1'b0; r_pend = 1'b0; auto_w = 1'b0; auto_r = 1'b0; stray_en = 1'b0;
        burst_left = 0; rv_limit = BW; rand_wait = 1'b0; ready_wait = 0; rv_pct = 100;
        blitw_sdram_request = 1'b0; blitr_sdram_request = 1'b0;
        sdram_ready = 1'b0; sdram_rvalid = 1'b0; sdram_complete = 1'b0;
        cycle();
        lit_zero = 1'b1;
        cycle();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic t_single_write();
        do_reset();
        ready_wait = 2;
        wq.push_back({26'h0001000, 4'hF, 32'hDEADBEEF});
        for (int i = 0; i < 50 && grants.size() < 1; i++) cycle();
        repeat (3) cycle();
        chk("t1_grants", 64'(grants.size()), 64'd1);
        if (grants.size() >= 1) begin
            chk("t1_write", 64'(grants[0].wr), 64'd1);
            chk("t1_addr", 64'(grants[0].addr), 64'h0001000);
            chk("t1_wstrb", 64'(grants[0].strb), 64'hF);
            chk("t1_wdata", 64'(grants[0].data), 64'hDEADBEEF);
        end
        chk("t1_req_cycles", 64'(req_cycles), 64'd3);
        chk("t1_wready_pulses", 64'(bw_ready_cnt), 64'd1);
        chk("t1_wready_without_sdram_ready", 64'(bw_bad), 64'd0);
    endtask

    task automatic t_single_read();
        do_reset();
        rv_pct = 60;
        rq.push_back(26'h0002000);
        for (int i = 0; i < 200 && cpl_cnt < 1; i++) cycle();
        repeat (3) cycle();
        chk("t2_beats", 64'(rv_addr.size()), 64'd4);
        chk("t2_complete_count", 64'(cpl_cnt), 64'd1);
        chk("t2_complete_on_beat", 64'(cpl_idx), 64'd4);
        for (int i = 0; i < rv_addr.size() && i < sent_data.size(); i++) begin
            chk("t2_raddress", 64'(rv_addr[i]), 64'h0002000 + 64'(4 * i));
            chk("t2_rdata", 64'(rv_data[i]), 64'(sent_data[i]));
        end
        wq.push_back({26'h0002010, 4'h3, 32'h12345678});
        for (int i = 0; i < 20 && grants.size() < 2; i++) cycle();
        chk("t2_idle_then_write", 64'(grants.size()), 64'd2);
    endtask

    task automatic t_write_run();
        int rd_idx[$];
        do_reset();
        auto_w = 1'b1; w_pct = 100; w_base = 26'h0005000;
        rq.push_back(26'h0002000);
        rq.push_back(26'h0002040);
        for (int i = 0; i < 400 && rd_grants < 2; i++) cycle();
        auto_w = 1'b0;
        for (int i = 0; i < grants.size(); i++) if (!grants[i].wr) rd_idx.push_back(i);
        chk("t3_reads_granted", 64'(rd_idx.size()), 64'd2);
        if (rd_idx.size() >= 2) begin
            chk("t3_first_run", 64'(rd_idx[0]), 64'd8);
            chk("t3_run_after_read", 64'(rd_idx[1] - rd_idx[0] - 1), 64'd8);
        end
        for (int i = 0; i < 100 && m_burst; i++) cycle();
    endtask

    task automatic t_hazard();
        do_reset();
        for (int i = 0; i < 8; i++) wq.push_back({26'h0005000 + 26'(4 * i), 4'hF, 32'(i)});
        wq.push_back({26'h0003004, 4'h5, 32'hCAFEF00D});
        wq.push_back({26'h0005100, 4'hF, 32'h11111111});
        wq.push_back({26'h0005104, 4'hF, 32'h22222222});
        rq.push_back(26'h0003000);
        for (int i = 0; i < 300 && grants.size() < 12; i++) cycle();
        chk("t4_grants", 64'(grants.size()), 64'd12);
        if (grants.size() >= 10) begin
            chk("t4_hazard_write_first", 64'({grants[8].wr, grants[8].addr}), {37'd0, 1'b1, 26'h0003004});
            chk("t4_read_follows", 64'({grants[9].wr, grants[9].addr}), {37'd0, 1'b0, 26'h0003000});
        end
    endtask

    task automatic t_reset_mid_burst();
        do_reset();
        rv_limit = 2;
        rq.push_back(26'h0002000);
        for (int i = 0; i < 100 && rv_addr.size() < 2; i++) cycle();
        chk("t5_beats_before_reset", 64'(rv_addr.size()), 64'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rv_limit = BW;
        lit_zero = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("t5_beats_after_reset", 64'(rv_addr.size()), 64'd2);
        chk("t5_complete_forwarded", 64'(cpl_cnt), 64'd0);
        chk("t5_stray_left", 64'(burst_left), 64'd0);
    endtask

    task automatic t_idle_then_both();
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        chk("t6_idle_requests", 64'(req_cycles), 64'd0);
        wq.push_back({26'h0004000, 4'hF, 32'hA5A5A5A5});
        rq.push_back(26'h0004100);
        for (int i = 0; i < 50 && grants.size() < 2; i++) cycle();
        chk("t6_grants", 64'(grants.size()), 64'd2);
        if (grants.size() >= 2) begin
            chk("t6_write_first", 64'(grants[0].wr), 64'd1);
            chk("t6_read_second", 64'(grants[1].wr), 64'd0);
        end
        for (int i = 0; i < 100 && m_burst; i++) cycle();
    endtask

    task automatic t_random();
        do_reset();
        auto_w = 1'b1; w_pct = 60; w_base = 26'h0100000;
        auto_r = 1'b1; r_pct = 30; r_base = 26'h0100000;
        rand_wait = 1'b1; rv_pct = 70; stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) cycle();
        chk("rand_progress", 64'(rd_grants > 20 && grants.size() > 200), 64'd1);
    endtask

    initial begin
        advance();
        lit_zero = 1'b1;
        cycle();
        t_single_write();
        t_single_read();
        t_write_run();
        t_hazard();
        t_reset_mid_burst();
        t_idle_then_both();
        t_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
